multiply_ntts_ctrl: RTL and testbench

//   Sequencer for MultiplyNTTs (FIPS 203 Alg. 11), acting as initiator for the base-case multiplier.
//   - Reads NTT-domain polynomials f and g from their coefficient RAMs, one pair per cycle.
//   - Reads the per-pair zeta from the zeta ROM.
//   - Streams (a0,a1,b0,b1,zeta) into the base-case multiplier and collects its (c0,c1) results.
//   - Writes the product polynomial h back to the result RAM and reports completion.

---
 rtl/multiply_ntts_ctrl.sv | 119 +++++++++++
 tb/tb_multiply_ntts_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_ntts_ctrl.sv
// multiply_ntts_ctrl: MultiplyNTTs sequencer that streams f/g/zeta pairs into the base-case
// multiplier and writes each (c0,c1) result back to the h RAM in issue order.
module multiply_ntts_ctrl #(
    parameter int N_PAIRS = 128,
    parameter int ADDR_W  = 7,
    parameter int MEM_LAT = 1,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [23:0]       f_rdata_i,
    input  logic [23:0]       g_rdata_i,
    input  logic [11:0]       zeta_i,
    output logic              mul_valid_o,
    output logic [11:0]       mul_a0_o,
    output logic [11:0]       mul_a1_o,
    output logic [11:0]       mul_b0_o,
    output logic [11:0]       mul_b1_o,
    output logic [11:0]       mul_zeta_o,
    input  logic              mul_valid_i,
    input  logic [11:0]       mul_c0_i,
    input  logic [11:0]       mul_c1_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [23:0]       wr_data_o
);
    localparam int CNT_W = ADDR_W + 1;

    if (MEM_LAT < 1 || MUL_LAT < 1) begin : g_bad_lat
        $error("multiply_ntts_ctrl: MEM_LAT and MUL_LAT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_iss_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic               r_rd_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [MEM_LAT-1:0] r_vld_sr;
    logic               w_active;
    logic               w_wr;
    logic               w_last_wr;

    assign w_active  = r_state == ISSUE || r_state == DRAIN;
    // A result is only accepted while a pair issued to the multiplier is still unanswered.
    assign w_wr      = w_active && mul_valid_i && r_wr_cnt < r_iss_cnt;
    assign w_last_wr = w_wr && r_wr_cnt == CNT_W'(N_PAIRS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rd_cnt  <= '0;
            r_iss_cnt <= '0;
            r_wr_cnt  <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_vld_sr  <= '0;
        end else begin
            r_vld_sr <= (r_vld_sr << 1) | MEM_LAT'(r_rd_en);
            r_done   <= 1'b0;
            if (mul_valid_o)
                r_iss_cnt <= r_iss_cnt + 1'b1;
            if (w_wr)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            if (mul_valid_i && !w_wr)
                r_err <= 1'b1;
            case (r_state)
                IDLE: if (start_i) begin
                    r_state   <= ISSUE;
                    r_rd_en   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_rd_cnt  <= '0;
                    r_iss_cnt <= '0;
                    r_wr_cnt  <= '0;
                end
                ISSUE: if (r_rd_cnt == CNT_W'(N_PAIRS - 1)) begin
                    r_state <= DRAIN;
                    r_rd_en <= 1'b0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                DRAIN: if (w_last_wr) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign rd_en_o     = r_rd_en;
    assign rd_addr_o   = r_rd_en ? r_rd_cnt[ADDR_W-1:0] : '0;
    assign mul_valid_o = r_vld_sr[MEM_LAT-1];
    // Operands are forced to zero outside a valid beat so idle outputs stay quiet.
    assign mul_a0_o    = mul_valid_o ? f_rdata_i[11:0]  : '0;
    assign mul_a1_o    = mul_valid_o ? f_rdata_i[23:12] : '0;
    assign mul_b0_o    = mul_valid_o ? g_rdata_i[11:0]  : '0;
    assign mul_b1_o    = mul_valid_o ? g_rdata_i[23:12] : '0;
    assign mul_zeta_o  = mul_valid_o ? zeta_i           : '0;
    assign wr_en_o     = w_wr;
    assign wr_addr_o   = w_wr ? r_wr_cnt[ADDR_W-1:0] : '0;
    assign wr_data_o   = w_wr ? {mul_c1_i, mul_c0_i} : '0;
endmodule

// File: tb/tb_multiply_ntts_ctrl.sv
// tb_multiply_ntts_ctrl: directed/random bench with RAM, ROM and multiplier models and a
// per-cycle activity log that is checked against the Alg. 11 golden product and timeline.
module tb_multiply_ntts_ctrl;
    localparam int Q    = 3329;
    localparam int LOGN = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, err_o, rd_en_o, mul_valid_o, wr_en_o, mul_valid_i;
    logic [6:0]  rd_addr_o, wr_addr_o;
    logic [23:0] f_rdata_i = '0, g_rdata_i = '0, wr_data_o;
    logic [11:0] zeta_i = '0, mul_a0_o, mul_a1_o, mul_b0_o, mul_b1_o, mul_zeta_o, mul_c0_i, mul_c1_i;

    always #5 clk = ~clk;

    multiply_ntts_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .f_rdata_i(f_rdata_i), .g_rdata_i(g_rdata_i),
        .zeta_i(zeta_i), .mul_valid_o(mul_valid_o), .mul_a0_o(mul_a0_o), .mul_a1_o(mul_a1_o),
        .mul_b0_o(mul_b0_o), .mul_b1_o(mul_b1_o), .mul_zeta_o(mul_zeta_o),
        .mul_valid_i(mul_valid_i), .mul_c0_i(mul_c0_i), .mul_c1_i(mul_c1_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    function automatic int mulq(input int a, input int b);
        return int'((longint'(a) * longint'(b)) % Q);
    endfunction

    function automatic int bitrev7(input int i);
        int r = 0;
        for (int k = 0; k < 7; k++) r |= ((i >> k) & 1) << (6 - k);
        return r;
    endfunction

    function automatic int gamma_of(input int i);
        int r = 1;
        for (int k = 0; k < 2 * bitrev7(i) + 1; k++) r = mulq(r, 17);
        return r;
    endfunction

    // BaseCaseMultiply: (a0 + a1 X)(b0 + b1 X) mod (X^2 - gamma), packed {c1, c0}
    function automatic logic [23:0] bcm(input int a0, input int a1, input int b0, input int b1, input int z);
        int c0 = (mulq(a0, b0) + mulq(mulq(a1, b1), z)) % Q;
        int c1 = (mulq(a0, b1) + mulq(a1, b0)) % Q;
        return {c1[11:0], c0[11:0]};
    endfunction

    // f/g RAMs and zeta ROM, one cycle read latency
    logic [23:0] fmem [128];
    logic [23:0] gmem [128];
    logic [11:0] zmem [128];
    always @(posedge clk) if (rd_en_o) begin
        f_rdata_i <= fmem[rd_addr_o];
        g_rdata_i <= gmem[rd_addr_o];
        zeta_i    <= zmem[rd_addr_o];
    end

    // Base-case multiplier model with 4-cycle latency, sharing rst
    logic [3:0]  p_v;
    logic [23:0] p_c [4];
    logic        force_v = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) p_v <= '0;
        else begin
            p_v    <= {p_v[2:0], mul_valid_o};
            p_c[0] <= bcm(int'(mul_a0_o), int'(mul_a1_o), int'(mul_b0_o), int'(mul_b1_o), int'(mul_zeta_o));
            for (int k = 1; k < 4; k++) p_c[k] <= p_c[k-1];
        end
    end
    assign mul_valid_i = p_v[3] | force_v;
    assign mul_c0_i    = p_c[3][11:0];
    assign mul_c1_i    = p_c[3][23:12];

    // Per-cycle activity log, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    bit          rd_l [LOGN];
    bit          mv_l [LOGN];
    bit          wr_l [LOGN];
    bit          dn_l [LOGN];
    bit          bz_l [LOGN];
    logic [6:0]  ra_l [LOGN];
    logic [6:0]  wa_l [LOGN];
    logic [23:0] wd_l [LOGN];
    always @(negedge clk) if (cyc < LOGN) begin
        rd_l[cyc] <= rd_en_o;
        mv_l[cyc] <= mul_valid_o;
        wr_l[cyc] <= wr_en_o;
        dn_l[cyc] <= done_o;
        bz_l[cyc] <= busy_o;
        ra_l[cyc] <= rd_addr_o;
        wa_l[cyc] <= wr_addr_o;
        wd_l[cyc] <= wr_data_o;
    end

    int checks = 0;
    int failures = 0;
    int rd_n, rd_f, rd_lst, mv_n, mv_f, mv_lst, wr_n, wr_f, wr_lst, dn_n, dn_c, bz_n, bz_f, bz_lst;
    bit rd_ord, wr_ord;
    logic [23:0] res [128];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int s);
        start_i = 1'b1;
        s = cyc;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_o !== 1'b1 && k < 300) begin
            step(1);
            k++;
        end
        chk({tag, "_done_timeout"}, k < 300, 1);
    endtask

    task automatic analyze(input int s, input int e);
        rd_n = 0; mv_n = 0; wr_n = 0; dn_n = 0; bz_n = 0;
        rd_f = -1; rd_lst = -1; mv_f = -1; mv_lst = -1; wr_f = -1; wr_lst = -1;
        dn_c = -1; bz_f = -1; bz_lst = -1; rd_ord = 1; wr_ord = 1;
        for (int i = 0; i < 128; i++) res[i] = 'x;
        for (int c = s; c <= e; c++) begin
            if (rd_l[c]) begin
                if (int'(ra_l[c]) != rd_n) rd_ord = 0;
                if (rd_f < 0) rd_f = c - s;
                rd_lst = c - s;
                rd_n++;
            end
            if (mv_l[c]) begin
                if (mv_f < 0) mv_f = c - s;
                mv_lst = c - s;
                mv_n++;
            end
            if (wr_l[c]) begin
                if (int'(wa_l[c]) != wr_n) wr_ord = 0;
                res[wa_l[c]] = wd_l[c];
                if (wr_f < 0) wr_f = c - s;
                wr_lst = c - s;
                wr_n++;
            end
            if (dn_l[c]) begin
                dn_c = c - s;
                dn_n++;
            end
            if (bz_l[c]) begin
                if (bz_f < 0) bz_f = c - s;
                bz_lst = c - s;
                bz_n++;
            end
        end
    endtask

    task automatic check_timeline(input string tag);
        chk({tag, "_rd_n"}, rd_n, 128);
        chk({tag, "_rd_first"}, rd_f, 1);
        chk({tag, "_rd_last"}, rd_lst, 128);
        chk({tag, "_rd_order"}, rd_ord, 1);
        chk({tag, "_mv_n"}, mv_n, 128);
        chk({tag, "_mv_first"}, mv_f, 2);
        chk({tag, "_mv_last"}, mv_lst, 129);
        chk({tag, "_wr_n"}, wr_n, 128);
        chk({tag, "_wr_first"}, wr_f, 6);
        chk({tag, "_wr_last"}, wr_lst, 133);
        chk({tag, "_wr_order"}, wr_ord, 1);
        chk({tag, "_done_n"}, dn_n, 1);
        chk({tag, "_done_cycle"}, dn_c, 134);
        chk({tag, "_busy_n"}, bz_n, 133);
        chk({tag, "_busy_first"}, bz_f, 1);
        chk({tag, "_busy_last"}, bz_lst, 133);
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy_o, done_o, err_o, rd_en_o, rd_addr_o, mul_valid_o, mul_a0_o, mul_a1_o,
                     mul_b0_o, mul_b1_o, mul_zeta_o, wr_en_o, wr_addr_o, wr_data_o});
    endfunction

    initial begin
        #200000;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, bad;
        for (int i = 0; i < 128; i++) begin
            fmem[i] = {12'd1, 12'd1};
            gmem[i] = {12'd1, 12'd1};
            zmem[i] = 12'd17;
        end
        step(3);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b1;
        step(2);
        chk("idle_outputs", all_outs(), 0);

        // all-ones operands, zeta 17: every pair {2, 18}
        pulse_start(s);
        wait_done("ones");
        chk("ones_done_at_134", cyc - s, 134);
        step(2);
        analyze(s, cyc - 1);
        check_timeline("ones");
        bad = 0;
        for (int i = 0; i < 128; i++) if (res[i] !== {12'd2, 12'd18}) bad++;
        chk("ones_bad_pairs", bad, 0);
        chk("ones_err", err_o, 0);

        // random operands with true gamma table against golden Alg. 11
        for (int i = 0; i < 128; i++) begin
            fmem[i] = {12'($urandom_range(0, Q - 1)), 12'($urandom_range(0, Q - 1))};
            gmem[i] = {12'($urandom_range(0, Q - 1)), 12'($urandom_range(0, Q - 1))};
            zmem[i] = 12'(gamma_of(i));
        end
        pulse_start(s);
        wait_done("rand");
        step(2);
        analyze(s, cyc - 1);
        check_timeline("rand");
        for (int i = 0; i < 128; i++)
            chk($sformatf("rand_h%0d", i), res[i],
                bcm(int'(fmem[i][11:0]), int'(fmem[i][23:12]), int'(gmem[i][11:0]), int'(gmem[i][23:12]),
                    gamma_of(i)));

        // second start at cycle 50 is ignored
        pulse_start(s);
        step(49);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        wait_done("dbl");
        step(2);
        analyze(s, cyc - 1);
        check_timeline("dbl");

        // start during DONE ignored, start in the following IDLE cycle runs a full pass
        pulse_start(s);
        wait_done("b2b1");
        chk("b2b1_done_at_134", cyc - s, 134);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        chk("b2b_idle_busy", busy_o, 0);
        chk("b2b_idle_rd_en", rd_en_o, 0);
        pulse_start(s2);
        chk("b2b_gap", s2 - s, 135);
        wait_done("b2b2");
        step(2);
        analyze(s, s2 - 1);
        chk("b2b1_wr_n", wr_n, 128);
        chk("b2b1_done_n", dn_n, 1);
        analyze(s2, cyc - 1);
        check_timeline("b2b2");

        // spurious multiplier result while idle
        chk("err_before", err_o, 0);
        force_v = 1'b1;
        #1;
        chk("spurious_no_wr", wr_en_o, 0);
        step(1);
        force_v = 1'b0;
        chk("err_set", err_o, 1);
        step(5);
        chk("err_sticky", err_o, 1);

        // asynchronous reset in cycle 70 of a run
        pulse_start(s);
        step(69);
        chk("rst_mid_rd_en", rd_en_o, 1);
        chk("rst_mid_busy", busy_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", all_outs(), 0);
        step(3);
        rst = 1'b1;
        step(80);
        analyze(s, cyc - 1);
        chk("rst_mid_no_done", dn_n, 0);
        chk("rst_mid_partial_writes", wr_n, 64);
        chk("rst_mid_err_cleared", err_o, 0);
        pulse_start(s);
        wait_done("restart");
        step(2);
        analyze(s, cyc - 1);
        check_timeline("restart");
        for (int i = 0; i < 128; i++)
            chk($sformatf("restart_h%0d", i), res[i],
                bcm(int'(fmem[i][11:0]), int'(fmem[i][23:12]), int'(gmem[i][11:0]), int'(gmem[i][23:12]),
                    gamma_of(i)));
        chk("restart_err", err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
